// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO UART transmitter: default bus addresses,
// status register bit positions and the serializer state encoding.
package mmio_pkg;

   localparam logic [15:0] DEF_DATA_ADDR   = 16'hFFFC;
   localparam logic [15:0] DEF_STATUS_ADDR = 16'hFFFD;

   localparam int STAT_BUSY = 0;
   localparam int STAT_FULL = 1;
   localparam int STAT_OVF  = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// MEM-stage data-port bus as seen by an MMIO responder: address, store
// data/strobe, load strobe and registered read data.
interface mmio_uart_tx_if;

   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_write;
   logic        mem_read;
   logic [15:0] mem_rdata;

   modport master (
      output mem_addr, mem_wdata, mem_write, mem_read,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_write, mem_read,
      output mem_rdata
   );

endinterface

// File: rtl/mmio_tx_fifo.sv
// Small synchronous FIFO for TX words. A push while full is ignored unless a
// pop happens in the same cycle, in which case both take effect.
module mmio_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // DEPTH is a power of two, so pointers wrap by natural overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO serial output peripheral: stores to DATA_ADDR are queued and sent as
// two 8N1 frames (low byte first); STATUS_ADDR reads {overflow, full, busy}.
module mmio_uart_tx
   import mmio_pkg::*;
#(
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [15:0] DATA_ADDR    = DEF_DATA_ADDR,
   parameter logic [15:0] STATUS_ADDR  = DEF_STATUS_ADDR
) (
   input  logic         clk,
   input  logic         reset,
   mmio_uart_tx_if.slave bus,
   output logic         tx,
   output logic         busy,
   output logic         overflow
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   tx_state_t     state, state_n;
   logic [BW-1:0] baud, baud_n;
   logic [2:0]    bit_idx, bit_n;
   logic          byte_sel, sel_n;
   logic [15:0]   word, word_n;
   logic          tx_n;

   logic          push_req;
   logic          status_hit;
   logic          pop;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic [15:0]   fifo_dout;
   logic          ovf_n;
   logic [15:0]   status;

   assign push_req   = bus.mem_write && (bus.mem_addr == DATA_ADDR);
   assign status_hit = (bus.mem_addr == STATUS_ADDR);
   assign busy       = (count != '0) || (state != ST_IDLE);

   mmio_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (16)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_req),
      .pop   (pop),
      .din   (bus.mem_wdata),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_comb begin
      status            = '0;
      status[STAT_BUSY] = busy;
      status[STAT_FULL] = full;
      status[STAT_OVF]  = overflow;
   end

   // A dropped store in the same cycle as a status read keeps the flag set
   always_comb begin
      ovf_n = overflow;
      if (push_req && full && !pop)
         ovf_n = 1'b1;
      else if (bus.mem_read && status_hit)
         ovf_n = 1'b0;
   end

   always_comb begin
      state_n = state;
      baud_n  = baud;
      bit_n   = bit_idx;
      sel_n   = byte_sel;
      word_n  = word;
      pop     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               word_n  = fifo_dout;
               sel_n   = 1'b0;
               baud_n  = '0;
               state_n = ST_START;
            end
         end
         ST_START: begin
            if (baud == BAUD_LAST) begin
               baud_n  = '0;
               bit_n   = '0;
               state_n = ST_DATA;
            end else begin
               baud_n = baud + 1'b1;
            end
         end
         ST_DATA: begin
            if (baud == BAUD_LAST) begin
               baud_n = '0;
               if (bit_idx == 3'd7) state_n = ST_STOP;
               else                 bit_n   = bit_idx + 1'b1;
            end else begin
               baud_n = baud + 1'b1;
            end
         end
         ST_STOP: begin
            if (baud == BAUD_LAST) begin
               baud_n = '0;
               if (!byte_sel) begin
                  sel_n   = 1'b1;
                  state_n = ST_START;
               end else if (!empty) begin
                  pop     = 1'b1;
                  word_n  = fifo_dout;
                  sel_n   = 1'b0;
                  state_n = ST_START;
               end else begin
                  state_n = ST_IDLE;
               end
            end else begin
               baud_n = baud + 1'b1;
            end
         end
      endcase
   end

   // tx follows the next state so the line level changes on the same edge
   always_comb begin
      unique case (state_n)
         ST_START: tx_n = 1'b0;
         ST_DATA:  tx_n = word_n[{sel_n, bit_n}];
         default:  tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         baud          <= '0;
         bit_idx       <= '0;
         byte_sel      <= 1'b0;
         tx            <= 1'b1;
         overflow      <= 1'b0;
         bus.mem_rdata <= '0;
      end else begin
         state    <= state_n;
         baud     <= baud_n;
         bit_idx  <= bit_n;
         byte_sel <= sel_n;
         tx       <= tx_n;
         overflow <= ovf_n;
         if (bus.mem_read)
            bus.mem_rdata <= status_hit ? status : 16'h0000;
      end
   end

   always_ff @(posedge clk) begin
      word <= word_n;
   end

endmodule
